// File: rtl/i2c_slave_rx_if.sv
// Pulse-level bus between the SCL/SDA edge detectors, the slave receiver and the register file.
// The detectors and register file use master; the receiver uses slave.
interface i2c_slave_rx_if;
    logic       sda;
    logic       scl_lohi;
    logic       scl_hilo;
    logic       sta;
    logic       sto;
    logic       sda_oe;
    logic       adr_hit;
    logic       rw;
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic       act;

    modport master (
        output sda, scl_lohi, scl_hilo, sta, sto,
        input  sda_oe, adr_hit, rw, rx_dat, rx_vld, act
    );

    modport slave (
        input  sda, scl_lohi, scl_hilo, sta, sto,
        output sda_oe, adr_hit, rw, rx_dat, rx_vld, act
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Byte-level I2C slave receiver: address match, ACK drive, write-data capture.
// adr_hit/rx_vld register on the 8th SCL rise; sda_oe registers on the SCL fall; no backpressure.
module i2c_slave_rx #(
    parameter logic [6:0] ADDR     = 7'h50,
    parameter bit         ACK_DATA = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    i2c_slave_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADR, ACK_A, DATA, ACK_D, SKIP} state_t;

    state_t     state, state_nxt;
    logic [7:0] sr, sr_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       ack_ph, ack_ph_nxt;
    logic       sda_oe_q, sda_oe_nxt;
    logic       adr_hit_q, adr_hit_nxt;
    logic       rw_q, rw_nxt;
    logic [7:0] rx_dat_q, rx_dat_nxt;
    logic       rx_vld_q, rx_vld_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= 8'h00;
            cnt       <= 4'd0;
            ack_ph    <= 1'b0;
            sda_oe_q  <= 1'b0;
            adr_hit_q <= 1'b0;
            rw_q      <= 1'b0;
            rx_dat_q  <= 8'h00;
            rx_vld_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            cnt       <= cnt_nxt;
            ack_ph    <= ack_ph_nxt;
            sda_oe_q  <= sda_oe_nxt;
            adr_hit_q <= adr_hit_nxt;
            rw_q      <= rw_nxt;
            rx_dat_q  <= rx_dat_nxt;
            rx_vld_q  <= rx_vld_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        cnt_nxt     = cnt;
        ack_ph_nxt  = ack_ph;
        sda_oe_nxt  = sda_oe_q;
        adr_hit_nxt = 1'b0;
        rw_nxt      = rw_q;
        rx_dat_nxt  = rx_dat_q;
        rx_vld_nxt  = 1'b0;

        if (bus.sta) begin
            state_nxt  = ADR;
            sr_nxt     = 8'h00;
            cnt_nxt    = 4'd0;
            ack_ph_nxt = 1'b0;
            sda_oe_nxt = 1'b0;
        end else if (bus.sto) begin
            state_nxt  = IDLE;
            sr_nxt     = 8'h00;
            cnt_nxt    = 4'd0;
            ack_ph_nxt = 1'b0;
            sda_oe_nxt = 1'b0;
        end else begin
            case (state)
                ADR, DATA: begin
                    if (bus.scl_lohi) begin
                        sr_nxt = {sr[6:0], bus.sda};
                        if (cnt == 4'd7) begin
                            // Byte completes on its 8th rise; results land in the very next cycle.
                            cnt_nxt = 4'd0;
                            if (state == ADR) begin
                                if (sr_nxt[7:1] == ADDR) begin
                                    adr_hit_nxt = 1'b1;
                                    rw_nxt      = sr_nxt[0];
                                    state_nxt   = ACK_A;
                                end else begin
                                    state_nxt = SKIP;
                                end
                            end else begin
                                rx_dat_nxt = sr_nxt;
                                rx_vld_nxt = 1'b1;
                                state_nxt  = ACK_D;
                            end
                        end else begin
                            cnt_nxt = cnt + 4'd1;
                        end
                    end
                end
                ACK_A, ACK_D: begin
                    // SDA moves only on SCL falls so the ACK can never mimic START/STOP.
                    if (bus.scl_hilo) begin
                        if (!ack_ph) begin
                            ack_ph_nxt = 1'b1;
                            sda_oe_nxt = (state == ACK_A) ? 1'b1 : ACK_DATA;
                        end else begin
                            ack_ph_nxt = 1'b0;
                            sda_oe_nxt = 1'b0;
                            state_nxt  = (state == ACK_D || !rw_q) ? DATA : SKIP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign bus.adr_hit = adr_hit_q;
    assign bus.rw      = rw_q;
    assign bus.rx_dat  = rx_dat_q;
    assign bus.rx_vld  = rx_vld_q;
    assign bus.act     = (state == ADR) || (state == ACK_A) || (state == DATA) || (state == ACK_D);
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx; u0 ACKs data bytes, u1 (ACK_DATA=0) leaves them NACKed.
module tb_i2c_slave_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sda = 1'b1, scl_lohi = 1'b0, scl_hilo = 1'b0, sta = 1'b0, sto = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2c_slave_rx_if bus0();
    i2c_slave_rx_if bus1();

    assign bus0.sda = sda;      assign bus1.sda = sda;
    assign bus0.scl_lohi = scl_lohi; assign bus1.scl_lohi = scl_lohi;
    assign bus0.scl_hilo = scl_hilo; assign bus1.scl_hilo = scl_hilo;
    assign bus0.sta = sta;      assign bus1.sta = sta;
    assign bus0.sto = sto;      assign bus1.sto = sto;

    i2c_slave_rx #(.ADDR(7'h50), .ACK_DATA(1'b1)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    i2c_slave_rx #(.ADDR(7'h50), .ACK_DATA(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Pulse monitors, sampled mid-cycle.
    int         hit_cnt = 0, vld_cnt = 0, oe_cnt = 0, vld_cnt1 = 0, oe_bad = 0;
    logic       hit_rw = 1'b0;
    logic [7:0] last_dat = 8'h00, last_dat1 = 8'h00;
    logic       ev = 1'b0, prev_oe = 1'b0;

    always @(posedge clk) ev <= scl_hilo | sta | sto;

    always @(negedge clk) begin
        if (bus0.adr_hit) begin hit_cnt++; hit_rw = bus0.rw; end
        if (bus0.rx_vld)  begin vld_cnt++; last_dat = bus0.rx_dat; end
        if (bus0.sda_oe)  oe_cnt++;
        if (bus1.rx_vld)  begin vld_cnt1++; last_dat1 = bus1.rx_dat; end
        if (!rst && (bus0.sda_oe !== prev_oe) && !ev) oe_bad++;
        prev_oe = bus0.sda_oe;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clk_bit(input logic b, output logic hit_l, output logic vld_l);
        sda = b; tick();
        scl_lohi = 1'b1; tick(); scl_lohi = 1'b0;
        hit_l = bus0.adr_hit; vld_l = bus0.rx_vld;
        tick();
        scl_hilo = 1'b1; tick(); scl_hilo = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic hit_l, output logic vld_l);
        for (int i = 7; i >= 0; i--) clk_bit(v[i], hit_l, vld_l);
    endtask

    task automatic ack_slot(output logic mid0, output logic after0, output logic mid1, output logic after1);
        sda = 1'b1; tick();
        scl_lohi = 1'b1; tick(); scl_lohi = 1'b0;
        mid0 = bus0.sda_oe; mid1 = bus1.sda_oe;
        tick();
        scl_hilo = 1'b1; tick(); scl_hilo = 1'b0;
        after0 = bus0.sda_oe; after1 = bus1.sda_oe;
        tick();
    endtask

    task automatic start_cond();
        sta = 1'b1; tick(); sta = 1'b0; tick();
    endtask

    task automatic stop_cond();
        sto = 1'b1; tick(); sto = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        checks++; if (bus0.sda_oe !== 1'b0)  begin errors++; $display("FAIL reset_sda_oe: got %b want 0", bus0.sda_oe); end
        checks++; if (bus0.adr_hit !== 1'b0) begin errors++; $display("FAIL reset_adr_hit: got %b want 0", bus0.adr_hit); end
        checks++; if (bus0.rw !== 1'b0)      begin errors++; $display("FAIL reset_rw: got %b want 0", bus0.rw); end
        checks++; if (bus0.rx_vld !== 1'b0)  begin errors++; $display("FAIL reset_rx_vld: got %b want 0", bus0.rx_vld); end
        checks++; if (bus0.act !== 1'b0)     begin errors++; $display("FAIL reset_act: got %b want 0", bus0.act); end
        checks++; if (bus0.rx_dat !== 8'h00) begin errors++; $display("FAIL reset_rx_dat: got %h want 00", bus0.rx_dat); end
        rst = 1'b0; tick();
    endtask

    task automatic test_write();
        logic hit_l, vld_l, m0, a0, m1, a1;
        int h0, v0;
        h0 = hit_cnt; v0 = vld_cnt;
        start_cond();
        checks++; if (bus0.act !== 1'b1) begin errors++; $display("FAIL wr_act_after_start: got %b want 1", bus0.act); end
        send_byte(8'hA0, hit_l, vld_l);
        checks++; if (hit_l !== 1'b1) begin errors++; $display("FAIL wr_adr_hit_latency: got %b want 1", hit_l); end
        checks++; if (hit_cnt - h0 !== 1) begin errors++; $display("FAIL wr_adr_hit_count: got %0d want 1", hit_cnt - h0); end
        checks++; if (hit_rw !== 1'b0) begin errors++; $display("FAIL wr_rw: got %b want 0", hit_rw); end
        checks++; if (bus0.sda_oe !== 1'b1) begin errors++; $display("FAIL wr_adr_ack_on: got %b want 1", bus0.sda_oe); end
        ack_slot(m0, a0, m1, a1);
        checks++; if (m0 !== 1'b1) begin errors++; $display("FAIL wr_adr_ack_mid: got %b want 1", m0); end
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wr_adr_ack_off: got %b want 0", a0); end
        send_byte(8'hA5, hit_l, vld_l);
        checks++; if (vld_l !== 1'b1) begin errors++; $display("FAIL wr_rx_vld_latency: got %b want 1", vld_l); end
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL wr_rx_vld_count: got %0d want 1", vld_cnt - v0); end
        checks++; if (last_dat !== 8'hA5) begin errors++; $display("FAIL wr_rx_dat: got %h want a5", last_dat); end
        checks++; if (bus0.sda_oe !== 1'b1) begin errors++; $display("FAIL wr_data_ack_on: got %b want 1", bus0.sda_oe); end
        ack_slot(m0, a0, m1, a1);
        checks++; if (m0 !== 1'b1) begin errors++; $display("FAIL wr_data_ack_mid: got %b want 1", m0); end
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wr_data_ack_off: got %b want 0", a0); end
        stop_cond();
        checks++; if (bus0.act !== 1'b0) begin errors++; $display("FAIL wr_act_after_stop: got %b want 0", bus0.act); end
    endtask

    task automatic test_mismatch();
        logic hit_l, vld_l, m0, a0, m1, a1;
        int h0, v0, o0;
        h0 = hit_cnt; v0 = vld_cnt; o0 = oe_cnt;
        start_cond();
        send_byte(8'hA2, hit_l, vld_l);
        ack_slot(m0, a0, m1, a1);
        send_byte(8'h3C, hit_l, vld_l);
        ack_slot(m0, a0, m1, a1);
        send_byte(8'hC3, hit_l, vld_l);
        ack_slot(m0, a0, m1, a1);
        stop_cond();
        checks++; if (hit_cnt - h0 !== 0) begin errors++; $display("FAIL mis_adr_hit: got %0d want 0", hit_cnt - h0); end
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL mis_rx_vld: got %0d want 0", vld_cnt - v0); end
        checks++; if (oe_cnt - o0 !== 0)  begin errors++; $display("FAIL mis_sda_oe: got %0d want 0", oe_cnt - o0); end
    endtask

    task automatic test_read();
        logic hit_l, vld_l, m0, a0, m1, a1;
        int h0, v0, o0;
        h0 = hit_cnt; v0 = vld_cnt;
        start_cond();
        send_byte(8'hA1, hit_l, vld_l);
        checks++; if (hit_cnt - h0 !== 1) begin errors++; $display("FAIL rd_adr_hit: got %0d want 1", hit_cnt - h0); end
        checks++; if (hit_rw !== 1'b1) begin errors++; $display("FAIL rd_rw: got %b want 1", hit_rw); end
        checks++; if (bus0.sda_oe !== 1'b1) begin errors++; $display("FAIL rd_ack_on: got %b want 1", bus0.sda_oe); end
        ack_slot(m0, a0, m1, a1);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL rd_ack_off: got %b want 0", a0); end
        o0 = oe_cnt;
        send_byte(8'h5A, hit_l, vld_l);
        ack_slot(m0, a0, m1, a1);
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL rd_no_rx_vld: got %0d want 0", vld_cnt - v0); end
        checks++; if (oe_cnt - o0 !== 0)  begin errors++; $display("FAIL rd_no_sda_oe: got %0d want 0", oe_cnt - o0); end
        stop_cond();
    endtask

    task automatic test_rep_start();
        logic hit_l, vld_l, m0, a0, m1, a1;
        int h0, v0;
        h0 = hit_cnt; v0 = vld_cnt;
        start_cond();
        send_byte(8'hA0, hit_l, vld_l);
        ack_slot(m0, a0, m1, a1);
        clk_bit(1'b1, hit_l, vld_l);
        clk_bit(1'b0, hit_l, vld_l);
        clk_bit(1'b1, hit_l, vld_l);
        clk_bit(1'b1, hit_l, vld_l);
        start_cond();
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL rs_no_rx_vld: got %0d want 0", vld_cnt - v0); end
        checks++; if (bus0.act !== 1'b1) begin errors++; $display("FAIL rs_act: got %b want 1", bus0.act); end
        send_byte(8'hA1, hit_l, vld_l);
        checks++; if (hit_l !== 1'b1) begin errors++; $display("FAIL rs_adr_hit_latency: got %b want 1", hit_l); end
        checks++; if (hit_cnt - h0 !== 2) begin errors++; $display("FAIL rs_adr_hit_count: got %0d want 2", hit_cnt - h0); end
        checks++; if (hit_rw !== 1'b1) begin errors++; $display("FAIL rs_rw: got %b want 1", hit_rw); end
        stop_cond();
    endtask

    task automatic test_stop_in_ack();
        logic hit_l, vld_l;
        start_cond();
        send_byte(8'hA0, hit_l, vld_l);
        checks++; if (bus0.sda_oe !== 1'b1) begin errors++; $display("FAIL sp_ack_on: got %b want 1", bus0.sda_oe); end
        sto = 1'b1; tick(); sto = 1'b0;
        checks++; if (bus0.sda_oe !== 1'b0) begin errors++; $display("FAIL sp_ack_released: got %b want 0", bus0.sda_oe); end
        checks++; if (bus0.act !== 1'b0) begin errors++; $display("FAIL sp_act: got %b want 0", bus0.act); end
        tick();
    endtask

    task automatic test_rst_in_ack();
        logic hit_l, vld_l;
        start_cond();
        send_byte(8'hA0, hit_l, vld_l);
        checks++; if (bus0.sda_oe !== 1'b1) begin errors++; $display("FAIL ra_ack_on: got %b want 1", bus0.sda_oe); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus0.sda_oe !== 1'b0) begin errors++; $display("FAIL ra_async_release: got %b want 0", bus0.sda_oe); end
        tick();
        rst = 1'b0; tick();
        checks++; if (bus0.act !== 1'b0) begin errors++; $display("FAIL ra_act: got %b want 0", bus0.act); end
    endtask

    task automatic test_ack_data0();
        logic hit_l, vld_l, m0, a0, m1, a1;
        int v1;
        v1 = vld_cnt1;
        start_cond();
        send_byte(8'hA0, hit_l, vld_l);
        checks++; if (bus1.sda_oe !== 1'b1) begin errors++; $display("FAIL nd_adr_ack_on: got %b want 1", bus1.sda_oe); end
        ack_slot(m0, a0, m1, a1);
        send_byte(8'h00, hit_l, vld_l);
        checks++; if (vld_cnt1 - v1 !== 1) begin errors++; $display("FAIL nd_vld_00: got %0d want 1", vld_cnt1 - v1); end
        checks++; if (last_dat1 !== 8'h00) begin errors++; $display("FAIL nd_dat_00: got %h want 00", last_dat1); end
        checks++; if (bus1.sda_oe !== 1'b0) begin errors++; $display("FAIL nd_oe_00: got %b want 0", bus1.sda_oe); end
        ack_slot(m0, a0, m1, a1);
        checks++; if (m1 !== 1'b0) begin errors++; $display("FAIL nd_oe_mid_00: got %b want 0", m1); end
        send_byte(8'hFF, hit_l, vld_l);
        checks++; if (vld_cnt1 - v1 !== 2) begin errors++; $display("FAIL nd_vld_ff: got %0d want 2", vld_cnt1 - v1); end
        checks++; if (last_dat1 !== 8'hFF) begin errors++; $display("FAIL nd_dat_ff: got %h want ff", last_dat1); end
        ack_slot(m0, a0, m1, a1);
        checks++; if (m1 !== 1'b0) begin errors++; $display("FAIL nd_oe_mid_ff: got %b want 0", m1); end
        checks++; if (m0 !== 1'b1) begin errors++; $display("FAIL nd_ref_ack_mid: got %b want 1", m0); end
        stop_cond();
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_rep_start();
        test_stop_in_ack();
        test_rst_in_ack();
        test_ack_data0();
        checks++; if (oe_bad !== 0) begin errors++; $display("FAIL sda_oe_change_timing: got %0d bad changes want 0", oe_bad); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
